// File: rtl/cp0_exc_sequencer_pkg.sv
// Shared CP0 definitions: op codes, register indices, sequencer FSM states.
// Imported by the sequencer interface users and the sequencer itself.
package cp0_exc_sequencer_pkg;

    localparam logic [2:0] CP0_MFC0    = 3'd0;
    localparam logic [2:0] CP0_MTC0    = 3'd1;
    localparam logic [2:0] CP0_BREAK   = 3'd2;
    localparam logic [2:0] CP0_SYSCALL = 3'd3;
    localparam logic [2:0] CP0_TEQ     = 3'd4;
    localparam logic [2:0] CP0_ERET    = 3'd5;
    localparam logic [2:0] CP0_NOP     = 3'b111;

    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= CP0_ERET;
    endfunction

    function automatic logic op_is_trap(input logic [2:0] op);
        return (op == CP0_BREAK) || (op == CP0_SYSCALL) || (op == CP0_TEQ);
    endfunction

endpackage

// File: rtl/cp0_exc_sequencer_if.sv
// CPU-request / CP0-register-file bundle for the CP0 sequencer.
// int_req only exists when CP0_EXC_INT_EN is defined.
interface cp0_exc_sequencer_if
`ifdef CP0_EXC_INT_EN
    #(parameter int INT_W = 6)
`endif
    ;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [4:0]  req_sel;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        cpu_stall;
    logic [2:0]  cp0_role;
    logic [4:0]  cp0_sel;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef CP0_EXC_INT_EN
    logic [INT_W-1:0] int_req;
`endif

    modport master (
`ifdef CP0_EXC_INT_EN
        output int_req,
`endif
        output req_valid, req_op, req_sel, req_wdata, req_pc, cp0_rdata,
        input  req_ready, cpu_stall, cp0_role, cp0_sel, cp0_wdata,
        input  rd_valid, rd_data, redirect, redirect_pc
    );

    modport slave (
`ifdef CP0_EXC_INT_EN
        input  int_req,
`endif
        input  req_valid, req_op, req_sel, req_wdata, req_pc, cp0_rdata,
        output req_ready, cpu_stall, cp0_role, cp0_sel, cp0_wdata,
        output rd_valid, rd_data, redirect, redirect_pc
    );

endinterface

// File: rtl/cp0_exc_sequencer.sv
// Sequences one CP0 op at a time (IDLE->ISSUE->CAPTURE->DONE), stalling the CPU and returning data/redirects.
// Optional interrupt entry path enabled by CP0_EXC_INT_EN.
module cp0_exc_sequencer
    import cp0_exc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
    input  logic                clk,
    input  logic                rst,
    cp0_exc_sequencer_if.slave  bus
);

    seq_state_e  state, state_nxt;
    logic [2:0]  op_q;
    logic [4:0]  sel_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] rd_data_q;
    logic [31:0] redirect_pc_q;
    logic        accept;
    logic        int_start;
    logic        start;

    assign accept = (state == ST_IDLE) && bus.req_valid && op_legal(bus.req_op);

`ifdef CP0_EXC_INT_EN
    // Masked from entry until the handler's eret completes.
    logic in_service;
    assign int_start = (state == ST_IDLE) && !accept && (|bus.int_req) && !in_service;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            in_service <= 1'b0;
        else if (int_start)
            in_service <= 1'b1;
        else if ((state == ST_DONE) && (op_q == CP0_ERET))
            in_service <= 1'b0;
    end
`else
    assign int_start = 1'b0;
`endif

    assign start = accept || int_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q          <= 3'd0;
            sel_q         <= 5'd0;
            wdata_q       <= 32'd0;
            pc_q          <= 32'd0;
            rd_data_q     <= 32'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            if (accept) begin
                op_q    <= bus.req_op;
                sel_q   <= bus.req_sel;
                wdata_q <= bus.req_wdata;
                pc_q    <= bus.req_pc;
            end else if (int_start) begin
                op_q    <= CP0_SYSCALL;
                sel_q   <= CP0_REG_EPC;
                wdata_q <= bus.req_pc;
                pc_q    <= bus.req_pc;
            end
            // CP0 registers its read port, so issue-cycle data lands here.
            if (state == ST_CAPTURE) begin
                if (op_q == CP0_MFC0)
                    rd_data_q <= bus.cp0_rdata;
                if (op_q == CP0_ERET)
                    redirect_pc_q <= bus.cp0_rdata;
                else if (op_is_trap(op_q))
                    redirect_pc_q <= EXC_VECTOR;
            end
        end
    end

    always_comb begin
        bus.req_ready = (state == ST_IDLE);
        bus.cpu_stall = (state != ST_IDLE) || start;
        bus.cp0_role  = CP0_NOP;
        bus.cp0_sel   = 5'd0;
        bus.cp0_wdata = 32'd0;
        bus.rd_valid  = 1'b0;
        bus.redirect  = 1'b0;
        case (state)
            ST_ISSUE: begin
                bus.cp0_role  = op_q;
                bus.cp0_sel   = (op_q == CP0_ERET) ? CP0_REG_EPC : sel_q;
                bus.cp0_wdata = (op_q == CP0_MTC0) ? wdata_q : pc_q;
            end
            ST_DONE: begin
                bus.rd_valid = (op_q == CP0_MFC0);
                bus.redirect = op_is_trap(op_q) || (op_q == CP0_ERET);
            end
            default: ;
        endcase
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Directed bench for cp0_exc_sequencer with a behavioural CP0 register file (STATUS resets to 1).
module tb_cp0_exc_sequencer;
    import cp0_exc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef CP0_EXC_INT_EN
    cp0_exc_sequencer_if #(.INT_W(6)) bus();
`else
    cp0_exc_sequencer_if bus();
`endif

    cp0_exc_sequencer #(.EXC_VECTOR(32'h0000_0004)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural CP0: registered read port, mtc0 writes, traps write EPC.
    logic [31:0] regs [0:31];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            regs[12] <= 32'd1;
            bus.cp0_rdata <= 32'd0;
        end else begin
            if (bus.cp0_role == CP0_MTC0)
                regs[bus.cp0_sel] <= bus.cp0_wdata;
            else if (bus.cp0_role == CP0_BREAK || bus.cp0_role == CP0_SYSCALL || bus.cp0_role == CP0_TEQ)
                regs[14] <= bus.cp0_wdata;
            bus.cp0_rdata <= regs[bus.cp0_sel];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          stall_cnt, role_cyc, rv_cnt, rdr_cnt, both_cnt;
    logic [2:0]  role_seen;
    logic [4:0]  sel_seen;
    logic [31:0] wd_seen, rv_data, rdr_pc;

    // Starts in IDLE at posedge+2; observes accept, ISSUE, CAPTURE, DONE and the following IDLE.
    task automatic do_op(input logic vld, input logic [2:0] op, input logic [4:0] sel,
                         input logic [31:0] wd, input logic [31:0] pc);
        stall_cnt = 0; role_cyc = 0; rv_cnt = 0; rdr_cnt = 0; both_cnt = 0;
        role_seen = 3'b111; sel_seen = 5'd0; wd_seen = 32'd0; rv_data = 32'd0; rdr_pc = 32'd0;
        bus.req_valid = vld; bus.req_op = op; bus.req_sel = sel;
        bus.req_wdata = wd;  bus.req_pc = pc;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                bus.req_valid = 1'b0;
                #1;
            end
            if (bus.cpu_stall) stall_cnt++;
            if (bus.cp0_role != 3'b111) begin
                role_cyc++;
                role_seen = bus.cp0_role;
                sel_seen  = bus.cp0_sel;
                wd_seen   = bus.cp0_wdata;
            end
            if (bus.rd_valid) begin rv_cnt++;  rv_data = bus.rd_data;     end
            if (bus.redirect) begin rdr_cnt++; rdr_pc  = bus.redirect_pc; end
            if (bus.rd_valid && bus.redirect) both_cnt++;
        end
    endtask

    int acc;

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_sel = 5'd0;
        bus.req_wdata = 32'd0; bus.req_pc = 32'd0;
`ifdef CP0_EXC_INT_EN
        bus.int_req = '0;
`endif
        #1 rst = 1'b0;
        #2;
        check("rst_req_ready",   {31'd0, bus.req_ready}, 32'd1);
        check("rst_cpu_stall",   {31'd0, bus.cpu_stall}, 32'd0);
        check("rst_cp0_role",    {29'd0, bus.cp0_role},  32'd7);
        check("rst_cp0_sel",     {27'd0, bus.cp0_sel},   32'd0);
        check("rst_cp0_wdata",   bus.cp0_wdata,          32'd0);
        check("rst_rd_valid",    {31'd0, bus.rd_valid},  32'd0);
        check("rst_rd_data",     bus.rd_data,            32'd0);
        check("rst_redirect",    {31'd0, bus.redirect},  32'd0);
        check("rst_redirect_pc", bus.redirect_pc,        32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #2;

        // mfc0 STATUS
        do_op(1'b1, CP0_MFC0, 5'd12, 32'd0, 32'h0000_1000);
        check("mfc0_role",      {29'd0, role_seen}, 32'd0);
        check("mfc0_sel",       {27'd0, sel_seen},  32'd12);
        check("mfc0_role_cyc",  role_cyc,           32'd1);
        check("mfc0_stall_cyc", stall_cnt,          32'd4);
        check("mfc0_rd_valid",  rv_cnt,             32'd1);
        check("mfc0_rd_data",   rv_data,            32'h0000_0001);
        check("mfc0_redirect",  rdr_cnt,            32'd0);

        // mtc0 then mfc0 of the same register
        do_op(1'b1, CP0_MTC0, 5'd5, 32'hDEAD_BEEF, 32'h0000_1004);
        check("mtc0_role",      {29'd0, role_seen}, 32'd1);
        check("mtc0_sel",       {27'd0, sel_seen},  32'd5);
        check("mtc0_wdata",     wd_seen,            32'hDEAD_BEEF);
        check("mtc0_pulses",    rv_cnt + rdr_cnt,   32'd0);
        check("mtc0_stall_cyc", stall_cnt,          32'd4);
        do_op(1'b1, CP0_MFC0, 5'd5, 32'd0, 32'h0000_1008);
        check("rdback_rd_data", rv_data,            32'hDEAD_BEEF);
        check("rdback_rd_valid", rv_cnt,            32'd1);
        check("rdback_redirect", rdr_cnt,           32'd0);

        // syscall then eret
        do_op(1'b1, CP0_SYSCALL, 5'd0, 32'h1111_2222, 32'h0040_0010);
        check("sys_role",       {29'd0, role_seen}, 32'd3);
        check("sys_wdata_pc",   wd_seen,            32'h0040_0010);
        check("sys_redirect",   rdr_cnt,            32'd1);
        check("sys_redirect_pc", rdr_pc,            32'h0000_0004);
        check("sys_rd_valid",   rv_cnt,             32'd0);
        do_op(1'b1, CP0_ERET, 5'd0, 32'd0, 32'h0000_2000);
        check("eret_role",      {29'd0, role_seen}, 32'd5);
        check("eret_sel",       {27'd0, sel_seen},  32'd14);
        check("eret_redirect",  rdr_cnt,            32'd1);
        check("eret_redirect_pc", rdr_pc,           32'h0040_0010);
        check("eret_no_overlap", both_cnt,          32'd0);

        // break: unconditional redirect to the vector
        do_op(1'b1, CP0_BREAK, 5'd0, 32'd0, 32'h0040_0040);
        check("break_redirect_pc", rdr_pc,          32'h0000_0004);
        check("break_role",     {29'd0, role_seen}, 32'd2);

        // illegal op is dropped
        bus.req_valid = 1'b1; bus.req_op = 3'd6;
        #1;
        check("illegal_stall",  {31'd0, bus.cpu_stall}, 32'd0);
        @(posedge clk); #2;
        check("illegal_role",   {29'd0, bus.cp0_role},  32'd7);
        check("illegal_ready",  {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b0;

        // req_valid held: one acceptance per IDLE visit
        acc = 0;
        bus.req_valid = 1'b1; bus.req_op = CP0_MTC0; bus.req_sel = 5'd6; bus.req_wdata = 32'h1234;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.req_valid && bus.req_ready) acc++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        #1;
        check("held_accepts",   acc,                    32'd2);
        check("held_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #2;

`ifdef CP0_EXC_INT_EN
        bus.int_req = 6'b000001;
        do_op(1'b0, CP0_MFC0, 5'd0, 32'd0, 32'h0040_0100);
        check("int_role",       {29'd0, role_seen}, 32'd3);
        check("int_wdata_pc",   wd_seen,            32'h0040_0100);
        check("int_redirect_pc", rdr_pc,            32'h0000_0004);
        check("int_stall_cyc",  stall_cnt,          32'd4);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.cpu_stall) acc++;
            @(posedge clk); #2;
        end
        check("int_masked",     acc,                32'd0);
        do_op(1'b1, CP0_ERET, 5'd0, 32'd0, 32'h0000_3000);
        check("int_eret_pc",    rdr_pc,             32'h0040_0100);
        check("int_eret_stall_reentry", stall_cnt,  32'd5);
        @(posedge clk); #2;
        check("int_reentry_role", {29'd0, bus.cp0_role}, 32'd3);
        bus.int_req = '0;
        repeat (3) @(posedge clk);
        #2;
`endif

        // reset during CAPTURE aborts cleanly
        bus.req_valid = 1'b1; bus.req_op = CP0_MFC0; bus.req_sel = 5'd12;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_ready",    {31'd0, bus.req_ready}, 32'd1);
        check("abort_role",     {29'd0, bus.cp0_role},  32'd7);
        check("abort_stall",    {31'd0, bus.cpu_stall}, 32'd0);
        check("abort_rd_data",  bus.rd_data,            32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.rd_valid || bus.redirect || bus.cpu_stall) acc++;
            @(posedge clk); #1;
        end
        check("abort_no_pulse", acc, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
